// File: rtl/audio_sample_scheduler.sv
// audio_sample_scheduler: audio clock generator plus sample FIFO feeding the hdmi core at the audio rate
module audio_sample_scheduler #(
   parameter int CLK_HZ      = 74250000,
   parameter int SAMPLE_HZ   = 48000,
   parameter int FIFO_DEPTH  = 16,
   parameter int PRIME_LEVEL = 8
) (
   input  logic                          clk_pixel,
   input  logic                          reset,
   input  logic                          enable,
   input  logic                          mute,
   input  logic                          wr_valid,
   input  logic [15:0]                   wr_left,
   input  logic [15:0]                   wr_right,
   output logic                          wr_ready,
   output logic                          clk_audio,
   output logic [15:0]                   sample_left,
   output logic [15:0]                   sample_right,
   output logic                          sample_strobe,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [7:0]                    underflow_count,
   output logic [1:0]                    state
);
   localparam int AW = $clog2(CLK_HZ);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;
   localparam logic [31:0] INC = 32'(2 * SAMPLE_HZ);
   localparam logic [31:0] CLK = 32'(CLK_HZ);
   localparam logic [1:0] IDLE = 2'd0, PRIME = 2'd1, RUN = 2'd2;

   logic [AW-1:0] acc;
   logic [31:0]   acc_sum;
   logic          wrap, pop_tick;
   logic [1:0]    state_nxt;
   logic [31:0]   mem [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic          push, pop, underrun, flush;
   logic [15:0]   left_nxt, right_nxt;

   assign acc_sum  = 32'(acc) + INC;
   assign wrap     = acc_sum >= CLK;
   assign pop_tick = wrap && clk_audio;

   // phase accumulator: free-running so clk_audio never stalls
   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         acc       <= '0;
         clk_audio <= 1'b0;
      end else begin
         acc       <= wrap ? AW'(acc_sum - CLK) : AW'(acc_sum);
         clk_audio <= clk_audio ^ wrap;
      end
   end

   // state register
   always_ff @(posedge clk_pixel)
      state <= reset ? IDLE : state_nxt;

   // next state: dropping enable wins over every other transition
   always_comb
      state_nxt = !enable ? IDLE :
                  state == IDLE ? PRIME :
                  (state == PRIME && fifo_level >= LW'(PRIME_LEVEL)) ? RUN :
                  underrun ? PRIME : state;

   // handshake, pop decisions and next sample values
   always_comb begin
      wr_ready  = state != IDLE && fifo_level != LW'(FIFO_DEPTH);
      push      = wr_valid && wr_ready;
      flush     = state == IDLE || !enable;
      pop       = pop_tick && state == RUN && fifo_level != '0;
      underrun  = pop_tick && state == RUN && fifo_level == '0;
      left_nxt  = (state != RUN || mute) ? '0 : pop ? mem[rd_ptr][31:16] : sample_left;
      right_nxt = (state != RUN || mute) ? '0 : pop ? mem[rd_ptr][15:0]  : sample_right;
   end

   // fifo pointers and occupancy; an empty fifo never bypasses a same-cycle push
   always_ff @(posedge clk_pixel) begin
      if (reset || flush) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         fifo_level <= fifo_level + LW'(push) - LW'(pop);
      end
   end

   // fifo storage, left word in the upper half
   always_ff @(posedge clk_pixel)
      if (push) mem[wr_ptr] <= {wr_left, wr_right};

   // sample outputs change only on the falling edge of clk_audio
   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         sample_left   <= '0;
         sample_right  <= '0;
         sample_strobe <= 1'b0;
      end else begin
         sample_strobe <= pop_tick;
         if (pop_tick) begin
            sample_left  <= left_nxt;
            sample_right <= right_nxt;
         end
      end
   end

   // saturating underrun counter, cleared only by reset
   always_ff @(posedge clk_pixel) begin
      if (reset) underflow_count <= '0;
      else if (underrun && underflow_count != 8'hFF) underflow_count <= underflow_count + 8'd1;
   end
endmodule

// File: tb/tb_audio_sample_scheduler.sv
// tb_audio_sample_scheduler: directed vector bench for audio_sample_scheduler
module tb_audio_sample_scheduler;
   logic        clk_pixel = 1'b0, reset = 1'b1, enable = 1'b0, mute = 1'b0, wr_valid = 1'b0;
   logic [15:0] wr_left = '0, wr_right = '0;
   logic        wr_ready, clk_audio, sample_strobe;
   logic [15:0] sample_left, sample_right;
   logic [2:0]  fifo_level;
   logic [7:0]  underflow_count;
   logic [1:0]  state;
   int tests = 0, fails = 0, cyc = 0;
   bit ok;

   typedef struct {
      int en, mu, wv, wl, wr, n;
      int st, lvl, rdy, stb, sl, sr, ufc;
   } vec_t;
   vec_t vt [24];
   vec_t v;

   audio_sample_scheduler #(
      .CLK_HZ(20), .SAMPLE_HZ(2), .FIFO_DEPTH(4), .PRIME_LEVEL(2)
   ) dut (
      .clk_pixel(clk_pixel), .reset(reset), .enable(enable), .mute(mute),
      .wr_valid(wr_valid), .wr_left(wr_left), .wr_right(wr_right), .wr_ready(wr_ready),
      .clk_audio(clk_audio), .sample_left(sample_left), .sample_right(sample_right),
      .sample_strobe(sample_strobe), .fifo_level(fifo_level),
      .underflow_count(underflow_count), .state(state)
   );

   always #5 clk_pixel = ~clk_pixel;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_pixel);
         #1;
         cyc++;
      end
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_state(input logic [1:0] s, input int lim, output bit hit);
      hit = state == s;
      for (int i = 0; i < lim && !hit; i++) begin
         step(1);
         hit = state == s;
      end
   endtask

   initial begin
      vt[0]  = '{1,0,0,'h0000,'h0000,1,  1,0,1,0,'h0000,'h0000,0};
      vt[1]  = '{1,0,1,'h1111,'hAAAA,1,  1,1,1,0,'h0000,'h0000,0};
      vt[2]  = '{1,0,1,'h2222,'hBBBB,1,  1,2,1,0,'h0000,'h0000,0};
      vt[3]  = '{1,0,0,'h0000,'h0000,1,  2,2,1,0,'h0000,'h0000,0};
      vt[4]  = '{1,0,0,'h0000,'h0000,5,  2,2,1,0,'h0000,'h0000,0};
      vt[5]  = '{1,0,0,'h0000,'h0000,1,  2,1,1,1,'h1111,'hAAAA,0};
      vt[6]  = '{1,0,0,'h0000,'h0000,10, 2,0,1,1,'h2222,'hBBBB,0};
      vt[7]  = '{1,0,0,'h0000,'h0000,10, 1,0,1,1,'h2222,'hBBBB,1};
      vt[8]  = '{1,0,1,'h3333,'hCCCC,1,  1,1,1,0,'h2222,'hBBBB,1};
      vt[9]  = '{1,0,1,'h4444,'hDDDD,1,  1,2,1,0,'h2222,'hBBBB,1};
      vt[10] = '{1,0,1,'h5555,'hEEEE,1,  2,3,1,0,'h2222,'hBBBB,1};
      vt[11] = '{1,0,1,'h6666,'hFFFF,1,  2,4,0,0,'h2222,'hBBBB,1};
      vt[12] = '{1,0,1,'h7777,'h9999,1,  2,4,0,0,'h2222,'hBBBB,1};
      vt[13] = '{1,0,0,'h0000,'h0000,4,  2,4,0,0,'h2222,'hBBBB,1};
      vt[14] = '{1,0,0,'h0000,'h0000,1,  2,3,1,1,'h3333,'hCCCC,1};
      vt[15] = '{1,0,0,'h0000,'h0000,9,  2,3,1,0,'h3333,'hCCCC,1};
      vt[16] = '{1,0,1,'h8888,'h1234,1,  2,3,1,1,'h4444,'hDDDD,1};
      vt[17] = '{1,1,0,'h0000,'h0000,10, 2,2,1,1,'h0000,'h0000,1};
      vt[18] = '{1,1,0,'h0000,'h0000,10, 2,1,1,1,'h0000,'h0000,1};
      vt[19] = '{1,0,0,'h0000,'h0000,10, 2,0,1,1,'h8888,'h1234,1};
      vt[20] = '{1,0,1,'h0101,'h0202,1,  2,1,1,0,'h8888,'h1234,1};
      vt[21] = '{1,0,1,'h0303,'h0404,1,  2,2,1,0,'h8888,'h1234,1};
      vt[22] = '{1,0,1,'h0505,'h0606,1,  2,3,1,0,'h8888,'h1234,1};
      vt[23] = '{0,0,0,'h0000,'h0000,1,  0,0,0,0,'h8888,'h1234,1};

      step(3);
      check("reset_state", 64'({clk_audio, state, fifo_level, wr_ready, sample_left, sample_right, sample_strobe, underflow_count}), 64'(0));
      reset = 1'b0;
      cyc = 0;

      for (int n = 1; n <= 40; n++) begin
         step(1);
         check($sformatf("idle_c%0d", cyc),
               64'({clk_audio, sample_strobe, sample_left, sample_right, wr_ready, state}),
               64'({1'((cyc / 5) % 2), 1'(cyc % 10 == 0), 32'h0, 1'b0, 2'd0}));
      end

      for (int i = 0; i < 24; i++) begin
         v = vt[i];
         enable   = 1'(v.en);
         mute     = 1'(v.mu);
         wr_valid = 1'(v.wv);
         wr_left  = 16'(v.wl);
         wr_right = 16'(v.wr);
         step(v.n);
         check($sformatf("vec%0d", i),
               64'({state, fifo_level, wr_ready, sample_strobe, sample_left, sample_right, underflow_count}),
               64'({2'(v.st), 3'(v.lvl), 1'(v.rdy), 1'(v.stb), 16'(v.sl), 16'(v.sr), 8'(v.ufc)}));
      end
      wr_valid = 1'b0;

      enable = 1'b1;
      step(1);
      wr_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wr_left  = 16'(i + 'h10);
         wr_right = 16'(i + 'h20);
         step(1);
      end
      wr_valid = 1'b0;
      check("run_level3", 64'({state, fifo_level}), 64'({2'd2, 3'd3}));
      reset = 1'b1;
      step(1);
      check("reset_mid_run", 64'({clk_audio, state, fifo_level, wr_ready, sample_left, sample_right, sample_strobe, underflow_count}), 64'(0));
      reset = 1'b0;

      wait_state(2'd1, 4, ok);
      check("prime_after_reset", 64'(ok), 64'(1));
      for (int k = 0; k < 300 && ok; k++) begin
         wr_valid = 1'b1;
         wr_left  = 16'(k);
         wr_right = 16'(~k);
         step(2);
         wr_valid = 1'b0;
         wait_state(2'd2, 4, ok);
         if (ok) wait_state(2'd1, 40, ok);
      end
      check("underrun_loop_sync", 64'(ok), 64'(1));
      check("ufc_saturated", 64'({state, underflow_count}), 64'({2'd1, 8'd255}));

      enable = 1'b0;
      step(1);
      check("ufc_kept_on_disable", 64'({state, fifo_level, wr_ready, underflow_count}), 64'({2'd0, 3'd0, 1'b0, 8'd255}));
      reset = 1'b1;
      step(1);
      check("ufc_cleared_by_reset", 64'({state, underflow_count}), 64'(0));
      reset = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
